// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame geometry,
// and the transmitter's frame constants.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 9;

  // Frame framing shared by transmitter and receiver
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS_DEF + 1;

  // Codes are visible on stateOUT, so the values are fixed
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    DATA  = 4'd2,
    STOP  = 4'd3,
    BREAK = 4'd4
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-FIFO/register-block signals; master side is the receiver.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
);
  logic                 fifo_full;
  logic [DATA_BITS-1:0] DATA_OUT;
  logic                 rx_write;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    input  fifo_full,
    output DATA_OUT, rx_write, framing_error, overrun
  );

  modport slave (
    output fifo_full,
    input  DATA_OUT, rx_write, framing_error, overrun
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-stage bit synchronizer for asynchronous pin inputs; resets to RESET_VAL.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {STAGES{RESET_VAL}};
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// UART receive path: oversampled start/data/stop recovery, pushes good
// words to the receive FIFO and flags framing and overrun faults.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              RX_IN,
  output logic [3:0]        stateOUT,
  uart_receiver_if.master   rx_if
);
  localparam int unsigned   TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  logic rxs;

  rx_state_e            state_q,     state_d;
  logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
  logic [3:0]           bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] data_out_q,  data_out_d;
  logic                 rx_write_q,  rx_write_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic [TW-1:0]        tick_wrap;

  uart_rx_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (RX_IN),
    .q     (rxs)
  );

  assign tick_wrap = (tick_cnt_q == LAST_CNT) ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    rx_write_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == MID_CNT) begin
            if (!rxs) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          tick_cnt_d = tick_wrap;
          if (tick_cnt_q == LAST_CNT) begin
            shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT) state_d = STOP;
          end
        end
        STOP: begin
          tick_cnt_d = tick_wrap;
          // Leaving at mid-stop lets a back-to-back start bit be caught in IDLE
          if (tick_cnt_q == LAST_CNT) begin
            if (!rxs) begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end else if (rx_if.fifo_full) begin
              overrun_d = 1'b1;
              state_d   = IDLE;
            end else begin
              data_out_d = shift_q;
              rx_write_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        BREAK: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_out_q  <= '0;
      rx_write_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      rx_write_q  <= rx_write_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign stateOUT            = state_q;
  assign rx_if.DATA_OUT      = data_out_q;
  assign rx_if.rx_write      = rx_write_q;
  assign rx_if.framing_error = frame_err_q;
  assign rx_if.overrun       = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: sample_tick every clk, 16 clk per bit.
module tb_uart_receiver;
  import uart_pkg::*;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       sample_tick = 1'b1;
  logic       RX_IN       = 1'b1;
  logic [3:0] stateOUT;

  int checks = 0;
  int errors = 0;

  int         wr_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [8:0] wr_data[$];

  uart_receiver_if #(.DATA_BITS(9)) rx_if();

  uart_receiver #(
    .OVERSAMPLE (16),
    .DATA_BITS  (9)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .RX_IN       (RX_IN),
    .stateOUT    (stateOUT),
    .rx_if       (rx_if.master)
  );

  always #5 clk = ~clk;

  // Every high cycle is counted, so a stretched strobe shows up as an extra count
  always @(negedge clk) begin
    if (rx_if.rx_write) begin
      wr_cnt++;
      wr_data.push_back(rx_if.DATA_OUT);
    end
    if (rx_if.framing_error) fe_cnt++;
    if (rx_if.overrun)       ov_cnt++;
  end

  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] data, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 9; i++) send_bit(data[i]);
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx_if.fifo_full = 1'b0;
    @(negedge clk);
    checks++; if (stateOUT !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", stateOUT); end
    checks++; if (rx_if.DATA_OUT !== 9'h000) begin errors++; $display("FAIL reset_data: got %0h expected 0", rx_if.DATA_OUT); end
    checks++; if (rx_if.rx_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %0b expected 0", rx_if.rx_write); end
    checks++; if (rx_if.framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", rx_if.framing_error); end
    checks++; if (rx_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %0b expected 0", rx_if.overrun); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    int wb = wr_cnt; int fb = fe_cnt; int ob = ov_cnt;
    send_frame(9'h1A5, 1'b1);
    send_bit(1'b1);
    checks++; if (wr_cnt - wb !== 1) begin errors++; $display("FAIL single_writes: got %0d expected 1", wr_cnt - wb); end
    checks++; if (wr_data[wb] !== 9'h1A5) begin errors++; $display("FAIL single_data: got %0h expected 1a5", wr_data[wb]); end
    checks++; if (fe_cnt - fb !== 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", fe_cnt - fb); end
    checks++; if (ov_cnt - ob !== 0) begin errors++; $display("FAIL single_ovr: got %0d expected 0", ov_cnt - ob); end
    checks++; if (stateOUT !== 4'd0) begin errors++; $display("FAIL single_state: got %0d expected 0", stateOUT); end
    checks++; if (rx_if.DATA_OUT !== 9'h1A5) begin errors++; $display("FAIL single_hold: got %0h expected 1a5", rx_if.DATA_OUT); end
  endtask

  task automatic test_back_to_back;
    int wb = wr_cnt;
    send_frame(9'h0FF, 1'b1);
    send_frame(9'h100, 1'b1);
    send_bit(1'b1);
    checks++; if (wr_cnt - wb !== 2) begin errors++; $display("FAIL b2b_writes: got %0d expected 2", wr_cnt - wb); end
    checks++; if (wr_data[wb] !== 9'h0FF) begin errors++; $display("FAIL b2b_first: got %0h expected 0ff", wr_data[wb]); end
    checks++; if (wr_data[wb+1] !== 9'h100) begin errors++; $display("FAIL b2b_second: got %0h expected 100", wr_data[wb+1]); end
  endtask

  task automatic test_glitch;
    int wb = wr_cnt; int fb = fe_cnt; int ob = ov_cnt;
    logic seen_start = 1'b0;
    RX_IN = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (stateOUT == 4'd1) seen_start = 1'b1;
    end
    RX_IN = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (stateOUT == 4'd1) seen_start = 1'b1;
    end
    checks++; if (seen_start !== 1'b1) begin errors++; $display("FAIL glitch_start: got %0b expected 1", seen_start); end
    checks++; if (stateOUT !== 4'd0) begin errors++; $display("FAIL glitch_idle: got %0d expected 0", stateOUT); end
    checks++; if ((wr_cnt - wb) + (fe_cnt - fb) + (ov_cnt - ob) !== 0) begin
      errors++; $display("FAIL glitch_strobes: got %0d expected 0", (wr_cnt - wb) + (fe_cnt - fb) + (ov_cnt - ob));
    end
  endtask

  task automatic test_break;
    int wb = wr_cnt; int fb = fe_cnt;
    send_frame(9'h055, 1'b0);
    repeat (40) send_bit(1'b0);
    checks++; if (fe_cnt - fb !== 1) begin errors++; $display("FAIL break_ferr: got %0d expected 1", fe_cnt - fb); end
    checks++; if (wr_cnt - wb !== 0) begin errors++; $display("FAIL break_writes: got %0d expected 0", wr_cnt - wb); end
    checks++; if (stateOUT !== 4'd4) begin errors++; $display("FAIL break_state: got %0d expected 4", stateOUT); end
    send_bit(1'b1);
    checks++; if (stateOUT !== 4'd0) begin errors++; $display("FAIL break_exit: got %0d expected 0", stateOUT); end
    send_frame(9'h033, 1'b1);
    send_bit(1'b1);
    checks++; if (wr_cnt - wb !== 1) begin errors++; $display("FAIL break_next_writes: got %0d expected 1", wr_cnt - wb); end
    checks++; if (wr_data[wb] !== 9'h033) begin errors++; $display("FAIL break_next_data: got %0h expected 033", wr_data[wb]); end
    checks++; if (fe_cnt - fb !== 1) begin errors++; $display("FAIL break_ferr_once: got %0d expected 1", fe_cnt - fb); end
  endtask

  task automatic test_overrun;
    int wb = wr_cnt; int ob = ov_cnt;
    rx_if.fifo_full = 1'b1;
    send_frame(9'h12C, 1'b1);
    send_bit(1'b1);
    checks++; if (ov_cnt - ob !== 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", ov_cnt - ob); end
    checks++; if (wr_cnt - wb !== 0) begin errors++; $display("FAIL ovr_writes: got %0d expected 0", wr_cnt - wb); end
    checks++; if (rx_if.DATA_OUT !== 9'h033) begin errors++; $display("FAIL ovr_hold: got %0h expected 033", rx_if.DATA_OUT); end
    rx_if.fifo_full = 1'b0;
    send_frame(9'h0C3, 1'b1);
    send_bit(1'b1);
    checks++; if (wr_cnt - wb !== 1) begin errors++; $display("FAIL ovr_next_writes: got %0d expected 1", wr_cnt - wb); end
    checks++; if (wr_data[wb] !== 9'h0C3) begin errors++; $display("FAIL ovr_next_data: got %0h expected 0c3", wr_data[wb]); end
    checks++; if (ov_cnt - ob !== 1) begin errors++; $display("FAIL ovr_once: got %0d expected 1", ov_cnt - ob); end
  endtask

  task automatic test_reset_mid_frame;
    int wb = wr_cnt; int fb = fe_cnt; int ob = ov_cnt;
    logic [8:0] word = 9'h1FE;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(word[i]);
    RX_IN = word[4];
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checks++; if (stateOUT !== 4'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", stateOUT); end
    checks++; if (rx_if.DATA_OUT !== 9'h000) begin errors++; $display("FAIL midrst_data: got %0h expected 0", rx_if.DATA_OUT); end
    RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1);
    checks++; if ((wr_cnt - wb) + (fe_cnt - fb) + (ov_cnt - ob) !== 0) begin
      errors++; $display("FAIL midrst_strobes: got %0d expected 0", (wr_cnt - wb) + (fe_cnt - fb) + (ov_cnt - ob));
    end
    send_frame(9'h1FE, 1'b1);
    send_bit(1'b1);
    checks++; if (wr_cnt - wb !== 1) begin errors++; $display("FAIL midrst_next_writes: got %0d expected 1", wr_cnt - wb); end
    checks++; if (wr_data[wb] !== 9'h1FE) begin errors++; $display("FAIL midrst_next_data: got %0h expected 1fe", wr_data[wb]); end
  endtask

  initial begin
    rx_if.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the UART IP. Recovers 11-bit asynchronous frames from a GPIO pin: start bit (0), nine data bits LSB first, and stop bit (1). Frame timing is taken from the shared baud-rate generator's oversample tick. Each good frame's nine data bits are pushed into the receive FIFO through a single-cycle write strobe. Framing and overrun faults are flagged to the register block.

## Interface
Parameters:
- OVERSAMPLE, 16: sample_tick pulses per bit period; must be even and at least 4.
- DATA_BITS, 9: data bits per frame (the ninth bit is the parity or user bit).

Ports:
- clk  in  1  common 50 MHz clock.
- reset  in  1  asynchronous, active-high.
- sample_tick  in  1  one-clk pulse at OVERSAMPLE × baud rate, from the baud generator.
- RX_IN  in  1  serial input from the pin; asynchronous to clk; idles high.
- fifo_full  in  1  receive FIFO full flag.
- DATA_OUT  out  DATA_BITS  last received word; valid when rx_write=1; holds its value otherwise.
- rx_write  out  1  one-clk pulse connected to the FIFO WRITE input.
- framing_error  out  1  one-clk pulse when the stop bit is sampled as 0.
- overrun  out  1  one-clk pulse when a good frame is dropped because fifo_full=1.
- stateOUT  out  4  current FSM state, for debug.

## Operation
- RX_IN passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the synchronized value rxs.
- The FSM and counters advance only on cycles with sample_tick=1. tick_cnt is log2(OVERSAMPLE) bits wide. bit_idx is 4 bits wide.
- States and stateOUT codes: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4. Unused codes return to IDLE.
- IDLE: on a tick with rxs=0, go to START and set tick_cnt=0.
- START: increment tick_cnt on each tick. At tick_cnt=OVERSAMPLE/2−1 (mid start bit):
  - rxs=0: go to DATA, clear tick_cnt, set bit_idx=0.
  - rxs=1: glitch or false start; go to IDLE with no flag.
- DATA: on each tick, tick_cnt wraps modulo OVERSAMPLE. When tick_cnt=OVERSAMPLE−1 (one full bit after the previous sample point):
  - shift_reg <= {rxs, shift_reg[DATA_BITS−1:1]};
  - bit_idx++.
  - After the sample with bit_idx=DATA_BITS−1, go to STOP.
- STOP: sample rxs when tick_cnt=OVERSAMPLE−1.
  - rxs=1 and fifo_full=0: DATA_OUT<=shift_reg; rx_write=1; go to IDLE.
  - rxs=1 and fifo_full=1: overrun=1; DATA_OUT unchanged; no write; go to IDLE.
  - rxs=0: framing_error=1; no write; go to BREAK.
- BREAK: stay until a tick with rxs=1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Because the FSM leaves STOP at mid-stop-bit, a back-to-back start bit is detected with no idle gap.
- Reset values: DATA_OUT=0, rx_write=0, framing_error=0, overrun=0, stateOUT=0 (IDLE), shift_reg=0, counters=0.
- Reset asserted mid-frame aborts immediately. No write or flag is produced for the partial frame.

## Timing
- Synchronizer latency: 2 clk from an RX_IN edge to rxs.
- Start detection happens on the first tick where rxs=0, so detection jitter is at most 1 tick.
- rx_write, framing_error and overrun are registered. Each asserts in the clk cycle after the stop-sample tick and is high for exactly 1 clk.
- rx_write, framing_error and overrun are mutually exclusive. None can fire twice per frame.
- Frame-to-strobe latency: about (1 + DATA_BITS + 0.5) × OVERSAMPLE ticks from the start-bit falling edge, plus 3 clk.
- fifo_full is sampled in the same cycle as the stop-sample tick.

## Structure
- Shared package uart_pkg holds:
  - the state enum/constants (IDLE, START, DATA, STOP, BREAK, 4-bit);
  - the default OVERSAMPLE and DATA_BITS values.
  The transmitter's frame constants move into the same package.
- One sub-module: uart_rx_sync (parameterizable-depth bit synchronizer, reset value 1). It is reusable for CTS and other pin inputs.

## Test plan
- Bench drives sample_tick every clk (16 clk per bit). Send frame 9'h1A5 → one rx_write pulse with DATA_OUT=9'h1A5; framing_error=0; overrun=0; stateOUT returns to 0.
- Send 9'h0FF and 9'h100 back-to-back with no idle → two rx_write pulses carrying those values in order.
- 3-tick low glitch on an idle line → FSM goes to START then back to IDLE; no strobe or flag.
- Frame 9'h055 with the stop bit forced to 0 and the line then held low for 40 bit times → one framing_error pulse; no rx_write; FSM stays in BREAK until the line goes high, then returns to IDLE; next frame 9'h033 is received correctly.
- fifo_full=1 during frame 9'h12C → one overrun pulse, no rx_write, DATA_OUT keeps its previous value. With fifo_full=0, the next frame 9'h0C3 is written normally.
- Assert reset at data bit 4 of a frame → all outputs 0 within 1 clk; no strobe. After reset is released, a fresh frame 9'h1FE is received correctly.
